mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 143 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer for the E stage.
// It owns the architectural HI/LO registers and runs one operation at a time.
// The result is computed when the operation is accepted. It is then held in
// result registers until a fixed-latency countdown commits it to HI/LO.
// Handshake: an operation is accepted only when start is high, which means an
// MD op is present, the unit is idle and there is no flush. While MD_hold is
// high, the hazard unit must keep MD-type instructions out of the E stage.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic        start,
    output logic        MD_hold,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        result_hi, result_lo;
    logic               div_by_zero;

    logic               is_md, is_div;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        divisor, abs_a, abs_b, mag_q, mag_r;
    logic [31:0]        nxt_hi, nxt_lo;

    assign is_md     = (MDop >= OP_MULT) && (MDop <= OP_DIVU);
    assign is_div    = (MDop == OP_DIV) || (MDop == OP_DIVU);
    assign busy      = (state == RUN);
    assign start     = is_md && !busy && !req;
    assign MD_hold   = start || busy;
    assign state_dbg = state;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: leave IDLE on an accepted op, and return when the countdown reaches 1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result datapath. The divisor is forced to 1 on zero so no x or trap is produced.
    // A zero divisor is flagged and suppresses the commit anyway.
    // Signed division works on magnitudes, so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'd0, A} * {32'd0, B};
        divisor = (B == 32'd0) ? 32'd1 : B;
        abs_a   = A[31] ? -A : A;
        abs_b   = divisor[31] ? -divisor : divisor;
        mag_q   = abs_a / abs_b;
        mag_r   = abs_a % abs_b;
        nxt_hi  = 32'd0;
        nxt_lo  = 32'd0;
        case (MDop)
            OP_MULT:  begin nxt_hi = prod_s[63:32]; nxt_lo = prod_s[31:0]; end
            OP_MULTU: begin nxt_hi = prod_u[63:32]; nxt_lo = prod_u[31:0]; end
            OP_DIV: begin
                nxt_lo = (A[31] ^ B[31]) ? -mag_q : mag_q;
                nxt_hi = A[31] ? -mag_r : mag_r;
            end
            OP_DIVU:  begin nxt_hi = A % divisor; nxt_lo = A / divisor; end
            default:  begin nxt_hi = 32'd0; nxt_lo = 32'd0; end
        endcase
    end

    // This block latches on start, counts down while busy, commits to HI/LO, and handles mthi/mtlo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            result_hi   <= 32'd0;
            result_lo   <= 32'd0;
            div_by_zero <= 1'b0;
            HI          <= 32'd0;
            LO          <= 32'd0;
        end else begin
            if (start) begin
                result_hi   <= nxt_hi;
                result_lo   <= nxt_lo;
                cnt         <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                div_by_zero <= is_div && (B == 32'd0);
            end else if (busy) begin
                if (cnt == CNT_W'(1)) begin
                    if (!div_by_zero) begin
                        HI <= result_hi;
                        LO <= result_lo;
                    end
                    cnt <= '0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
            // A move is ignored while busy. The commit only happens while busy, so the two never collide.
            if (!busy && !req) begin
                if (MDop == OP_MTHI) HI <= A;
                if (MDop == OP_MTLO) LO <= A;
            end
        end
    end

    // Zero-latency read of the current HI/LO. A result committing this cycle is not bypassed.
    always_comb begin
        MDout = 32'd0;
        if (MDop == OP_MFHI)      MDout = HI;
        else if (MDop == OP_MFLO) MDout = LO;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl. It uses directed vectors. The expected commits and
// reads are queued at issue time, and a negedge monitor pops and compares them.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  MDop = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        req = 1'b0;
    logic        busy, start, MD_hold;
    logic [31:0] HI, LO, MDout;
    logic [1:0]  state_dbg;

    // Marks a cycle in which MDout must match the head of rd_q.
    logic        rd_chk = 1'b0;

    // Each entry holds {hi[31:0], lo[31:0], busy_cycles[7:0]}.
    logic [71:0] exp_q[$];
    logic [31:0] rd_q[$];

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .MDop(MDop), .A(A), .B(B), .req(req),
        .busy(busy), .start(start), .MD_hold(MD_hold), .HI(HI), .LO(LO),
        .MDout(MDout), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks commits on the falling edge of busy, and checks reads when rd_chk is set.
    initial begin
        logic        prev_busy;
        int          busy_len;
        logic [71:0] e;
        logic [31:0] r;
        prev_busy = 1'b0;
        busy_len  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                busy_len  = 0;
            end else begin
                if (busy) busy_len++;
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit", HI, LO);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_hi", HI, e[71:40]);
                        check("commit_lo", LO, e[39:8]);
                        check("busy_cycles", 32'(busy_len), {24'd0, e[7:0]});
                    end
                    busy_len = 0;
                end
                prev_busy = busy;
                if (rd_chk) begin
                    if (rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_read: got %h expected no read", MDout);
                    end else begin
                        r = rd_q.pop_front();
                        check("mdout", MDout, r);
                    end
                end
            end
        end
    end

    // Driver tasks. Each one starts and ends 1 time unit after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic r, input logic exp_start);
        MDop = op; A = a; B = b; req = r;
        @(negedge clk);
        check("start", {31'd0, start}, {31'd0, exp_start});
        check("md_hold", {31'd0, MD_hold}, {31'd0, exp_start});
        @(posedge clk); #1;
        MDop = 4'd0; A = 32'd0; B = 32'd0; req = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL busy_timeout: got busy=%b expected 0 within 40 cycles", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic op_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int lat);
        exp_q.push_back({hi, lo, 8'(lat)});
        issue(op, a, b, 1'b0, 1'b1);
        wait_idle();
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic r);
        MDop = op; A = a; req = r;
        @(posedge clk); #1;
        MDop = 4'd0; A = 32'd0; req = 1'b0;
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] exp);
        rd_q.push_back(exp);
        MDop = op; rd_chk = 1'b1;
        @(posedge clk); #1;
        MDop = 4'd0; rd_chk = 1'b0;
    endtask

    // Directed stimulus
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Multiply: -2*3 signed, then the same operands unsigned.
        op_run(4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        op_run(4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);

        // Signed divide, including the overflow corner case.
        op_run(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        op_run(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);

        // Divide by zero leaves the preset HI/LO in place.
        mt(4'd7, 32'h11, 1'b0);
        mt(4'd8, 32'h22, 1'b0);
        rd(4'd5, 32'h11);
        rd(4'd6, 32'h22);
        op_run(4'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10);

        // A flush blocks both start and a move.
        issue(4'd1, 32'd2, 32'd3, 1'b1, 1'b0);
        check("req_busy", {31'd0, busy}, 32'd0);
        mt(4'd7, 32'h99, 1'b1);
        check("req_hi", HI, 32'h11);
        check("req_lo", LO, 32'h22);

        // An op presented while busy, a flush while busy, and a move while busy are all ignored.
        exp_q.push_back({32'd0, 32'h1E, 8'd5});
        issue(4'd1, 32'd5, 32'd6, 1'b0, 1'b1);
        MDop = 4'd1; A = 32'd7; B = 32'd7;
        @(negedge clk);
        check("busy_op_start", {31'd0, start}, 32'd0);
        check("busy_md_hold", {31'd0, MD_hold}, 32'd1);
        @(posedge clk); #1;
        MDop = 4'd0; A = 32'd0; B = 32'd0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; MDop = 4'd7; A = 32'hDEADBEEF;
        @(posedge clk); #1;
        MDop = 4'd0; A = 32'd0;
        wait_idle();

        // Move, then read.
        mt(4'd7, 32'h12345678, 1'b0);
        rd(4'd5, 32'h12345678);
        rd(4'd6, 32'h0000001E);
        rd(4'd0, 32'h00000000);

        // Reset in the middle of a divide.
        issue(4'd3, 32'd100, 32'd7, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // After reset, operations complete normally.
        op_run(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5);
        op_run(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
